// File: rtl/probe_sweep_ctrl.sv
// Selector sweep controller for the Datapath core: resets the core per
// (ledSel, ssdSel) combination, runs it, and folds leds/ssd into a MISR.
module probe_sweep_ctrl #(
   parameter int LED_SEL_W = 2,
   parameter int SSD_SEL_W = 4,
   parameter int LED_W     = 16,
   parameter int SSD_W     = 13,
   parameter int CYC_W     = 8,
   parameter int SIG_W     = 32,
   parameter logic [SIG_W-1:0] SIG_POLY = 32'h04C11DB7
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           abort,
   input  logic                           single_mode,
   input  logic [LED_SEL_W+SSD_SEL_W-1:0] combo_sel,
   input  logic [CYC_W-1:0]               run_cycles,
   input  logic [SIG_W-1:0]               sig_expected,
   input  logic [LED_W-1:0]               leds,
   input  logic [SSD_W-1:0]               ssd,
   output logic                           dut_rst,
   output logic [LED_SEL_W-1:0]           led_sel,
   output logic [SSD_SEL_W-1:0]           ssd_sel,
   output logic                           sample_valid,
   output logic [LED_SEL_W+SSD_SEL_W-1:0] combo_idx,
   output logic [CYC_W-1:0]               cycle_idx,
   output logic [SIG_W-1:0]               signature,
   output logic                           busy,
   output logic                           done,
   output logic                           pass
);

   localparam int CMB_W = LED_SEL_W + SSD_SEL_W;
   localparam int DAT_W = LED_W + SSD_W;

   typedef enum logic [1:0] {IDLE, RST_DUT, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic               single_q, single_d;
   logic [CYC_W-1:0]   runc_q, runc_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic [CMB_W-1:0]   combo_q, combo_d;
   logic [SIG_W-1:0]   sig_q, sig_d;
   logic               abrt_q, abrt_d;
   logic [SIG_W-1:0]   samp, misr;
   logic               launch, kill, last, final_cmb;

   assign launch    = start & ((state_q == IDLE) | (state_q == DONE));
   // abort alongside a start from IDLE still lands in DONE
   assign kill      = abort & ((state_q != IDLE) | start);
   assign last      = cyc_q == (runc_q - CYC_W'(1));
   assign final_cmb = single_q | (&combo_q);

   always_comb begin
      samp = '0;
      samp[DAT_W-1:0] = {leds, ssd};
      misr = {sig_q[SIG_W-2:0], 1'b0}
           ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
           ^ samp;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         single_q <= 1'b0;
         runc_q   <= '0;
         cyc_q    <= '0;
         combo_q  <= '0;
         sig_q    <= '0;
         abrt_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         single_q <= single_d;
         runc_q   <= runc_d;
         cyc_q    <= cyc_d;
         combo_q  <= combo_d;
         sig_q    <= sig_d;
         abrt_q   <= abrt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (kill) begin
         state_d = DONE;
      end else begin
         unique case (state_q)
            IDLE:    if (start) state_d = RST_DUT;
            RST_DUT: state_d = RUN;
            RUN:     if (last) state_d = final_cmb ? DONE : RST_DUT;
            DONE:    if (start) state_d = RST_DUT;
         endcase
      end
   end

   always_comb begin
      single_d = single_q;
      runc_d   = runc_q;
      cyc_d    = cyc_q;
      combo_d  = combo_q;
      sig_d    = sig_q;
      abrt_d   = abrt_q;
      if (kill) begin
         abrt_d = 1'b1;
      end else if (launch) begin
         single_d = single_mode;
         runc_d   = (run_cycles == '0) ? CYC_W'(1) : run_cycles;
         combo_d  = single_mode ? combo_sel : '0;
         cyc_d    = '0;
         sig_d    = '0;
         abrt_d   = 1'b0;
      end else if (state_q == RUN) begin
         sig_d = misr;
         if (last) begin
            cyc_d = '0;
            if (!final_cmb) combo_d = combo_q + CMB_W'(1);
         end else begin
            cyc_d = cyc_q + CYC_W'(1);
         end
      end
   end

   always_comb begin
      dut_rst      = state_q != RUN;
      sample_valid = state_q == RUN;
      busy         = (state_q == RST_DUT) | (state_q == RUN);
      done         = state_q == DONE;
      pass         = done & (sig_q == sig_expected) & ~abrt_q;
      led_sel      = combo_q[CMB_W-1:SSD_SEL_W];
      ssd_sel      = combo_q[SSD_SEL_W-1:0];
      combo_idx    = combo_q;
      cycle_idx    = cyc_q;
      signature    = sig_q;
   end

endmodule

// File: tb/tb_probe_sweep_ctrl.sv
// Directed bench for probe_sweep_ctrl: sweep length, MISR values,
// selector stability, abort, busy-start and async reset behaviour.
module tb_probe_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        single_mode = 1'b0;
   logic [5:0]  combo_sel = '0;
   logic [7:0]  run_cycles = '0;
   logic [31:0] sig_expected = '0;
   logic [15:0] leds = '0;
   logic [12:0] ssd = '0;
   logic        dut_rst, sample_valid, busy, done, pass;
   logic [1:0]  led_sel;
   logic [3:0]  ssd_sel;
   logic [5:0]  combo_idx;
   logic [7:0]  cycle_idx;
   logic [31:0] signature;

   int n_pass = 0;
   int n_total = 0;

   probe_sweep_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .single_mode(single_mode), .combo_sel(combo_sel),
      .run_cycles(run_cycles), .sig_expected(sig_expected),
      .leds(leds), .ssd(ssd), .dut_rst(dut_rst),
      .led_sel(led_sel), .ssd_sel(ssd_sel),
      .sample_valid(sample_valid), .combo_idx(combo_idx),
      .cycle_idx(cycle_idx), .signature(signature),
      .busy(busy), .done(done), .pass(pass)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic sm, input logic [5:0] cs,
                         input logic [7:0] rc);
      single_mode = sm;
      combo_sel   = cs;
      run_cycles  = rc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      n_total++; if (dut_rst !== 1'b1) $display("FAIL rst_dut_rst: got %b want 1", dut_rst); else n_pass++;
      n_total++; if ({busy, done, sample_valid} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {busy, done, sample_valid}); else n_pass++;
      rst = 1'b1;
      tick();
      n_total++; if (dut_rst !== 1'b1) $display("FAIL idle_dut_rst: got %b want 1", dut_rst); else n_pass++;
      n_total++; if ({busy, done, pass} !== 3'b000) $display("FAIL idle_flags: got %b want 000", {busy, done, pass}); else n_pass++;
      n_total++; if (signature !== 32'h0) $display("FAIL idle_sig: got %h want 0", signature); else n_pass++;
      n_total++; if ({led_sel, ssd_sel} !== 6'h00) $display("FAIL idle_sel: got %h want 00", {led_sel, ssd_sel}); else n_pass++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_total++; if ({busy, done} !== 2'b00) $display("FAIL idle_abort: got %b want 00", {busy, done}); else n_pass++;
   endtask

   task automatic test_full_sweep();
      int n, rsts, bad, expc;
      leds = '0; ssd = '0; sig_expected = '0;
      launch(1'b0, 6'h00, 8'd12);
      n = 0; rsts = 0; bad = 0; expc = 0;
      while (!done && n < 2000) begin
         if (busy && dut_rst) begin
            if (combo_idx !== 6'(expc)) bad++;
            expc++;
            rsts++;
         end
         tick();
         n++;
      end
      n_total++; if (n !== 832) $display("FAIL sweep_len: got %0d want 832", n); else n_pass++;
      n_total++; if (rsts !== 64) $display("FAIL sweep_rsts: got %0d want 64", rsts); else n_pass++;
      n_total++; if (bad !== 0) $display("FAIL sweep_order: got %0d bad want 0", bad); else n_pass++;
      n_total++; if (combo_idx !== 6'h3F) $display("FAIL sweep_last: got %h want 3f", combo_idx); else n_pass++;
      n_total++; if ({signature, pass} !== {32'h0, 1'b1}) $display("FAIL sweep_pass: got %h/%b want 0/1", signature, pass); else n_pass++;
   endtask

   task automatic test_single();
      int n, sv, selbad, cycbad;
      leds = '0; ssd = 13'h1; sig_expected = 32'h7;
      launch(1'b1, 6'b10_0011, 8'd3);
      n = 0; sv = 0; selbad = 0; cycbad = 0;
      while (!done && n < 2000) begin
         if (busy && (led_sel !== 2'b10 || ssd_sel !== 4'b0011)) selbad++;
         if (sample_valid) begin
            if (cycle_idx !== 8'(sv)) cycbad++;
            sv++;
         end
         tick();
         n++;
      end
      n_total++; if (n !== 4) $display("FAIL single_len: got %0d want 4", n); else n_pass++;
      n_total++; if (sv !== 3) $display("FAIL single_valid: got %0d want 3", sv); else n_pass++;
      n_total++; if (selbad !== 0) $display("FAIL single_sel: got %0d bad want 0", selbad); else n_pass++;
      n_total++; if (cycbad !== 0) $display("FAIL single_cyc: got %0d bad want 0", cycbad); else n_pass++;
      n_total++; if (signature !== 32'h7) $display("FAIL single_sig: got %h want 00000007", signature); else n_pass++;
      n_total++; if ({pass, dut_rst} !== 2'b11) $display("FAIL single_pass: got %b want 11", {pass, dut_rst}); else n_pass++;
   endtask

   task automatic test_mismatch();
      int n;
      sig_expected = 32'h6;
      launch(1'b1, 6'b10_0011, 8'd3);
      wait_done(n);
      n_total++; if ({done, pass} !== 2'b10) $display("FAIL mismatch: got %b want 10", {done, pass}); else n_pass++;
   endtask

   task automatic test_misr_poly();
      int n;
      leds = 16'hFFFF; ssd = 13'h1FFF; sig_expected = 32'h5B3EE242;
      launch(1'b1, 6'h00, 8'd5);
      wait_done(n);
      n_total++; if (n !== 6) $display("FAIL poly_len: got %0d want 6", n); else n_pass++;
      n_total++; if (signature !== 32'h5B3EE242) $display("FAIL poly_sig: got %h want 5b3ee242", signature); else n_pass++;
      n_total++; if (pass !== 1'b1) $display("FAIL poly_pass: got %b want 1", pass); else n_pass++;
   endtask

   task automatic test_abort();
      int n;
      leds = '0; ssd = '0; sig_expected = '0;
      launch(1'b0, 6'h00, 8'd3);
      n = 0;
      while (!(combo_idx == 6'd5 && sample_valid) && n < 500) begin
         tick();
         n++;
      end
      n_total++; if (n >= 500) $display("FAIL abort_reach: got %0d cycles want <500", n); else n_pass++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_total++; if ({done, pass, dut_rst, busy} !== 4'b1010) $display("FAIL abort_state: got %b want 1010", {done, pass, dut_rst, busy}); else n_pass++;
      tick();
      n_total++; if ({done, pass} !== 2'b10) $display("FAIL abort_sticky: got %b want 10", {done, pass}); else n_pass++;
      leds = 16'h0001; ssd = '0; sig_expected = 32'h0000E000;
      launch(1'b1, 6'h3F, 8'd3);
      wait_done(n);
      n_total++; if (signature !== 32'h0000E000) $display("FAIL rerun_sig: got %h want 0000e000", signature); else n_pass++;
      n_total++; if (pass !== 1'b1) $display("FAIL rerun_pass: got %b want 1", pass); else n_pass++;
   endtask

   task automatic test_run_zero();
      int n;
      leds = '0; ssd = '0; sig_expected = '0;
      launch(1'b0, 6'h00, 8'd0);
      wait_done(n);
      n_total++; if (n !== 128) $display("FAIL zero_len: got %0d want 128", n); else n_pass++;
      n_total++; if (pass !== 1'b1) $display("FAIL zero_pass: got %b want 1", pass); else n_pass++;
   endtask

   task automatic test_start_busy();
      int n;
      leds = '0; ssd = '0; sig_expected = '0;
      launch(1'b0, 6'h00, 8'd3);
      n = 0;
      while (!(combo_idx == 6'd2 && sample_valid && cycle_idx == 8'd0) && n < 1000) begin
         tick();
         n++;
      end
      single_mode = 1'b1; combo_sel = 6'h3F; run_cycles = 8'd7;
      start = 1'b1;
      tick();
      n++;
      start = 1'b0;
      n_total++; if ({busy, combo_idx, cycle_idx} !== {1'b1, 6'd2, 8'd1}) $display("FAIL busy_start: got %b/%0d/%0d want 1/2/1", busy, combo_idx, cycle_idx); else n_pass++;
      while (!done && n < 1000) begin
         tick();
         n++;
      end
      n_total++; if (n !== 256) $display("FAIL busy_len: got %0d want 256", n); else n_pass++;
   endtask

   task automatic test_mid_rst();
      leds = 16'h00A5; ssd = 13'h0011;
      launch(1'b0, 6'h00, 8'd4);
      repeat (22) tick();
      rst = 1'b0;
      #1;
      n_total++; if ({dut_rst, busy, sample_valid} !== 3'b100) $display("FAIL arst_flags: got %b want 100", {dut_rst, busy, sample_valid}); else n_pass++;
      n_total++; if ({combo_idx, cycle_idx} !== 14'h0) $display("FAIL arst_idx: got %h/%h want 0/0", combo_idx, cycle_idx); else n_pass++;
      n_total++; if (signature !== 32'h0) $display("FAIL arst_sig: got %h want 0", signature); else n_pass++;
      #3;
      rst = 1'b1;
      tick();
      n_total++; if ({busy, done, dut_rst} !== 3'b001) $display("FAIL arst_idle: got %b want 001", {busy, done, dut_rst}); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_full_sweep();
      test_single();
      test_mismatch();
      test_misr_poly();
      test_abort();
      test_run_zero();
      test_start_busy();
      test_mid_rst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
